// File: rtl/div_rem_unit_if.sv
// Handshake and operand bus between the control unit and the divide/remainder unit.
interface div_rem_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_signal;
  logic [1:0]            op_select;
  logic [DATA_WIDTH-1:0] dividend_input;
  logic [DATA_WIDTH-1:0] divisor_input;
  logic                  busy_signal;
  logic                  done_signal;
  logic [DATA_WIDTH-1:0] out_result_data;

  modport master (
    output start_signal, op_select, dividend_input, divisor_input,
    input  busy_signal, done_signal, out_result_data
  );

  modport slave (
    input  start_signal, op_select, dividend_input, divisor_input,
    output busy_signal, done_signal, out_result_data
  );
endinterface

// File: rtl/div_rem_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU; one quotient bit per clock.
//   state  | meaning
//   S_IDLE | waiting for start_signal
//   S_CALC | restoring iterations in progress, busy_signal high
//   S_DONE | out_result_data valid, done_signal high for this cycle
module div_rem_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  div_rem_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         state, state_next;
  logic [1:0]     op_q;
  logic [W-1:0]   quo, rem, dsr, result;
  logic [CW-1:0]  count;
  logic           neg_quo, neg_rem;

  logic           accept, last_step;
  logic           signed_in, is_rem_in, div_zero, sgn_ovf, special;
  logic [W-1:0]   special_result, dvd_abs, dvs_abs;
  logic [W:0]     rem_sh, diff;
  logic [W-1:0]   quo_step, rem_step, final_result;

  // op_select[0] selects unsigned, op_select[1] selects remainder
  always_comb begin
    signed_in = ~bus.op_select[0];
    is_rem_in = bus.op_select[1];
    div_zero  = (bus.divisor_input == '0);
    sgn_ovf   = signed_in && (bus.dividend_input == {1'b1, {(W-1){1'b0}}})
                && (bus.divisor_input == '1);
    special   = div_zero || sgn_ovf;
    if (div_zero)
      special_result = is_rem_in ? bus.dividend_input : '1;
    else
      special_result = is_rem_in ? '0 : {1'b1, {(W-1){1'b0}}};
    dvd_abs = (signed_in && bus.dividend_input[W-1]) ? -bus.dividend_input : bus.dividend_input;
    dvs_abs = (signed_in && bus.divisor_input[W-1])  ? -bus.divisor_input  : bus.divisor_input;
  end

  // Shifted partial remainder needs W+1 bits; bit W of the difference is the borrow.
  always_comb begin
    rem_sh = {rem, quo[W-1]};
    diff   = rem_sh - {1'b0, dsr};
    if (!diff[W]) begin
      rem_step = diff[W-1:0];
      quo_step = {quo[W-2:0], 1'b1};
    end else begin
      rem_step = rem_sh[W-1:0];
      quo_step = {quo[W-2:0], 1'b0};
    end
    last_step = (count == CW'(W-1));
    if (op_q[1])
      final_result = neg_rem ? -rem_step : rem_step;
    else
      final_result = neg_quo ? -quo_step : quo_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.start_signal) begin
          accept     = 1'b1;
          state_next = special ? S_DONE : S_CALC;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CALC: if (last_step) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      quo     <= '0;
      rem     <= '0;
      dsr     <= '0;
      count   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      op_q    <= bus.op_select;
      quo     <= dvd_abs;
      dsr     <= dvs_abs;
      rem     <= '0;
      count   <= '0;
      neg_quo <= signed_in && (bus.dividend_input[W-1] ^ bus.divisor_input[W-1]);
      neg_rem <= signed_in && bus.dividend_input[W-1];
      if (special) result <= special_result;
    end else if (state == S_CALC) begin
      quo   <= quo_step;
      rem   <= rem_step;
      count <= count + 1'b1;
      if (last_step) result <= final_result;
    end
  end

  assign bus.busy_signal     = (state == S_CALC);
  assign bus.done_signal     = (state == S_DONE);
  assign bus.out_result_data = result;
endmodule

// File: tb/tb_div_rem_unit.sv
// Self-checking bench for div_rem_unit: directed table, handshake/reset sequences, random ops vs arithmetic model.
module tb_div_rem_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  div_rem_unit_if #(.DATA_WIDTH(32)) bus ();
  div_rem_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic scramble();
    bus.op_select      = 2'($urandom_range(0, 3));
    bus.dividend_input = $urandom;
    bus.divisor_input  = $urandom;
  endtask

  // Issue one op and measure done cycle / busy cycles relative to the start edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, input bit disturb, input string name);
    logic [31:0] exp;
    bit          sp;
    int          done_cyc, busy_cnt;
    exp = model(op, a, b);
    sp  = is_special(op, a, b);
    if (!b2b) begin
      @(negedge clk);
      check({name, "_done_pulse"}, {31'd0, bus.done_signal}, 32'd0);
    end
    bus.op_select      = op;
    bus.dividend_input = a;
    bus.divisor_input  = b;
    bus.start_signal   = 1'b1;
    @(posedge clk);
    done_cyc = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.start_signal = 1'b0;
        scramble();
      end
      if (disturb && cyc == 10) begin
        bus.start_signal = 1'b1;
        scramble();
      end
      if (disturb && cyc == 11) bus.start_signal = 1'b0;
      if (bus.busy_signal) busy_cnt++;
      if (bus.done_signal) done_cyc = cyc;
    end
    check({name, "_result"}, bus.out_result_data, exp);
    check({name, "_done_cycle"}, 32'(done_cyc), sp ? 32'd1 : 32'd33);
    check({name, "_busy_cycles"}, 32'(busy_cnt), sp ? 32'd0 : 32'd32);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         "divu_100_7"};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          "remu_100_7"};
    vecs[2]  = '{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  "div_m100_7"};
    vecs[3]  = '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  "rem_m100_7"};
    vecs[4]  = '{2'b00, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  "div_100_m7"};
    vecs[5]  = '{2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,          "rem_100_m7"};
    vecs[6]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  "divu_by0"};
    vecs[7]  = '{2'b11, 32'd5,          32'd0,          32'd5,          "remu_by0"};
    vecs[8]  = '{2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  "div_by0"};
    vecs[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf"};
    vecs[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "rem_ovf"};
    vecs[11] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "divu_big"};
    vecs[12] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "remu_big"};

    rst_n              = 1'b0;
    bus.start_signal   = 1'b0;
    bus.op_select      = 2'b00;
    bus.dividend_input = '0;
    bus.divisor_input  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",   {31'd0, bus.busy_signal}, 32'd0);
    check("reset_done",   {31'd0, bus.done_signal}, 32'd0);
    check("reset_result", bus.out_result_data, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      check({vecs[i].name, "_model"}, model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, vecs[i].name);
    end

    // start pulse and operand change mid-CALC must be ignored
    run_op(2'b01, 32'd1000, 32'd10, 1'b0, 1'b1, "divu_disturb");
    // back-to-back issue while in DONE
    run_op(2'b01, 32'd9, 32'd3, 1'b1, 1'b0, "divu_b2b");
    repeat (5) @(negedge clk);
    check("hold_result", bus.out_result_data, 32'd3);
    check("hold_busy",   {31'd0, bus.busy_signal}, 32'd0);
    check("hold_done",   {31'd0, bus.done_signal}, 32'd0);

    // asynchronous reset in the middle of CALC
    bus.op_select      = 2'b01;
    bus.dividend_input = 32'h1234_5678;
    bus.divisor_input  = 32'd3;
    bus.start_signal   = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start_signal = 1'b0;
    end
    check("pre_reset_busy", {31'd0, bus.busy_signal}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy",   {31'd0, bus.busy_signal}, 32'd0);
    check("async_reset_done",   {31'd0, bus.done_signal}, 32'd0);
    check("async_reset_result", bus.out_result_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "divu_after_reset");

    for (int n = 0; n < 150; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, ($urandom_range(0, 3) == 0), 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
